// File: rtl/barrel_shifter.sv
// Registered 3-stage logarithmic barrel shifter with one cycle of latency.
// Build option: define BARREL_ROTATE_EN to enable circular rotate.
module barrel_shifter #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned SHAMT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  Ip,
    input  logic [SHAMT_W-1:0] shift_mag,
    input  logic               dir,
    input  logic               arith,
    input  logic               rotate,
    input  logic               in_valid,
    output logic [DATA_W-1:0]  Op,
    output logic               out_valid
);

    logic [DATA_W-1:0]             w_in;
    logic [DATA_W-1:0]             w_res;
    logic [SHAMT_W:0][DATA_W-1:0]  w_stage;
    logic                          w_fill_bit;
    logic                          w_unused_rotate;
    logic [DATA_W-1:0]             r_op;
    logic                          r_valid;

    // Left shifts are done as right shifts on the bit-reversed operand.
    always_comb begin
        w_in = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_in[i] = dir ? Ip[i] : Ip[DATA_W-1-i];
        end
    end

    assign w_fill_bit      = dir & arith & Ip[DATA_W-1];
    assign w_unused_rotate = rotate;
    assign w_stage[0]      = w_in;

    for (genvar g = 0; g < SHAMT_W; g++) begin : g_stage
        localparam int unsigned S = 1 << g;
        logic [S-1:0] w_fill;
`ifdef BARREL_ROTATE_EN
        assign w_fill = rotate ? w_stage[g][S-1:0] : {S{w_fill_bit}};
`else
        assign w_fill = {S{w_fill_bit}};
`endif
        assign w_stage[g+1] = shift_mag[g] ? {w_fill, w_stage[g][DATA_W-1:S]}
                                           : w_stage[g];
    end

    always_comb begin
        w_res = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_res[i] = dir ? w_stage[SHAMT_W][i] : w_stage[SHAMT_W][DATA_W-1-i];
        end
    end

    // Output register: captures only on qualified inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_op <= w_res;
            end
        end
    end

    assign Op        = r_op;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_barrel_shifter.sv
// Self-checking bench for barrel_shifter: directed vectors plus randomized
// traffic against an arithmetic reference model.
module tb_barrel_shifter;

`ifdef BARREL_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ip = '0;
    logic [2:0] shift_mag = '0;
    logic       dir = 1'b0;
    logic       arith = 1'b0;
    logic       rotate = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] op;
    logic       out_valid;

    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] exp_op = '0;

    barrel_shifter #(.DATA_W(8), .SHAMT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .Ip(ip), .shift_mag(shift_mag), .dir(dir),
        .arith(arith), .rotate(rotate), .in_valid(in_valid),
        .Op(op), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [7:0] v, input int sh,
                                         input logic d, input logic a, input logic r);
        if (sh == 0) return v;
        if (r && ROT_EN) begin
            if (!d) return 8'((v << sh) | (v >> (8 - sh)));
            else    return 8'((v >> sh) | (v << (8 - sh)));
        end
        if (!d) return 8'(v << sh);
        if (a)  return 8'($signed(v) >>> sh);
        return 8'(v >> sh);
    endfunction

    task automatic drive(input logic [7:0] v, input logic [2:0] sh, input logic d,
                         input logic a, input logic r, input logic vld);
        @(negedge clk);
        ip = v; shift_mag = sh; dir = d; arith = a; rotate = r; in_valid = vld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ip = 8'hA5; shift_mag = 3'd1; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (op !== 8'h00 || out_valid !== 1'b0) $display("FAIL reset_hold: op=%h valid=%b want 00/0", op, out_valid);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        n_total++;
        if (op !== 8'h00 || out_valid !== 1'b0) $display("FAIL reset_release_idle: op=%h valid=%b want 00/0", op, out_valid);
        else n_pass++;
        drive(8'h03, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        n_total++;
        if (op !== 8'h0C || out_valid !== 1'b1) $display("FAIL first_after_reset: op=%h valid=%b want 0c/1", op, out_valid);
        else n_pass++;
        exp_op = 8'h0C;
    endtask

    task automatic test_directed();
        logic [7:0] vec_ip  [8] = '{8'd16, 8'd4, 8'd4, 8'h80, 8'h80, 8'h81, 8'hFF, 8'h5A};
        logic [2:0] vec_sh  [8] = '{3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd1, 3'd7, 3'd0};
        logic       vec_dir [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       vec_ar  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       vec_rot [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] vec_exp [8];
        vec_exp = '{8'd64, 8'd1, 8'd16, 8'hF0, 8'h10,
                    (ROT_EN ? 8'h03 : 8'h02), 8'h80, 8'h5A};
        for (int i = 0; i < 8; i++) begin
            drive(vec_ip[i], vec_sh[i], vec_dir[i], vec_ar[i], vec_rot[i], 1'b1);
            tick();
            n_total++;
            if (op !== vec_exp[i] || out_valid !== 1'b1)
                $display("FAIL directed_%0d: op=%h valid=%b want %h/1", i, op, out_valid, vec_exp[i]);
            else n_pass++;
        end
        // 8'hFF << 7 then idle: output must hold
        drive(8'hFF, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(8'h11, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        n_total++;
        if (op !== 8'h80 || out_valid !== 1'b0) $display("FAIL hold_idle: op=%h valid=%b want 80/0", op, out_valid);
        else n_pass++;
        exp_op = 8'h80;
    endtask

    task automatic test_random();
        logic [7:0] v;
        logic [2:0] sh;
        logic d, a, r, vld;
        int bad = 0;
        for (int i = 0; i < 300; i++) begin
            v = 8'($urandom); sh = 3'($urandom); d = 1'($urandom);
            a = 1'($urandom); r = 1'($urandom); vld = ($urandom_range(0, 3) != 0);
            drive(v, sh, d, a, r, vld);
            if (vld) exp_op = model(v, int'(sh), d, a, r);
            tick();
            n_total++;
            if (op !== exp_op || out_valid !== vld) begin
                if (bad < 10)
                    $display("FAIL random_%0d: ip=%h sh=%0d dir=%b ar=%b rot=%b op=%h valid=%b want %h/%b",
                             i, v, sh, d, a, r, op, out_valid, exp_op, vld);
                bad++;
            end else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        logic [2:0] sh;
        for (int i = 0; i < 16; i++) begin
            v = 8'($urandom); sh = 3'(i);
            drive(v, sh, 1'b1, 1'b1, 1'b0, 1'b1);
            exp_op = model(v, int'(sh), 1'b1, 1'b1, 1'b0);
            tick();
            n_total++;
            if (op !== exp_op || out_valid !== 1'b1)
                $display("FAIL back_to_back_%0d: op=%h valid=%b want %h/1", i, op, out_valid, exp_op);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        drive(8'h5A, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        n_total++;
        if (op !== 8'hB4 || out_valid !== 1'b1) $display("FAIL pre_reset: op=%h valid=%b want b4/1", op, out_valid);
        else n_pass++;
        drive(8'h77, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (op !== 8'h00 || out_valid !== 1'b0) $display("FAIL async_reset: op=%h valid=%b want 00/0", op, out_valid);
        else n_pass++;
        tick();
        n_total++;
        if (op !== 8'h00 || out_valid !== 1'b0) $display("FAIL reset_over_edge: op=%h valid=%b want 00/0", op, out_valid);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        n_total++;
        if (op !== 8'h00 || out_valid !== 1'b0) $display("FAIL no_stale: op=%h valid=%b want 00/0", op, out_valid);
        else n_pass++;
        drive(8'h77, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        n_total++;
        if (op !== 8'h1D || out_valid !== 1'b1) $display("FAIL post_reset: op=%h valid=%b want 1d/1", op, out_valid);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
